multi_sensor_door_ctrl: RTL and testbench

Parametrised automatic-door controller, the successor to the single-sensor automatic door block. It merges N presence sensors through per-channel synchronisers and debounce filters. It drives separate open and close motor commands from a travel-position counter, holds the door open on a retriggerable timer, and reverses a closing door when presence returns. It sits between the raw sensor pins and the motor driver stage.

---
 rtl/door_ctrl_pkg.sv | 18 +
 rtl/door_sensor_filter.sv | 43 ++++
 rtl/multi_sensor_door_ctrl.sv | 141 ++++++++++++++
 tb/tb_multi_sensor_door_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/door_ctrl_pkg.sv
// Shared types and constants for the multi-sensor automatic door controller.
// Used by door_sensor_filter and multi_sensor_door_ctrl.
package door_ctrl_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        CLOSED    = 2'd0,
        OPENING   = 2'd1,
        OPEN_HOLD = 2'd2,
        CLOSING   = 2'd3
    } door_state_t;

    function automatic logic is_moving(input door_state_t s);
        return (s == OPENING) || (s == CLOSING);
    endfunction

endpackage

// File: rtl/door_sensor_filter.sv
// One presence channel: SYNC_STAGES-flop synchroniser followed by a debounce filter
// that flips only after DEBOUNCE consecutive synced samples disagree with it.
module door_sensor_filter
    import door_ctrl_pkg::*;
#(
    parameter int DEBOUNCE = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_filt
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_filt;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign o_filt   = r_filt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
            // Any agreeing sample restarts the count, so only an unbroken run flips the output.
            if (w_synced == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE - 1)) begin
                r_filt <= w_synced;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/multi_sensor_door_ctrl.sv
// Automatic door controller: N debounced presence sensors, travel-position counter,
// retriggerable hold-open timer and reversal on presence. Optional lock: DOOR_LOCK_EN.
module multi_sensor_door_ctrl
    import door_ctrl_pkg::*;
#(
    parameter int NUM_SENSORS = 2,
    parameter int TRAVEL      = 8,
    parameter int HOLD_TIME   = 16,
    parameter int DEBOUNCE    = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_SENSORS-1:0] i_sensor,
`ifdef DOOR_LOCK_EN
    input  logic                   i_lock,
`endif
    output logic                   o_motor_open,
    output logic                   o_motor_close,
    output logic                   o_door_output_state,
    output logic                   o_door_full_open
);

    localparam int PW = $clog2(TRAVEL + 1);
    localparam int HW = $clog2(HOLD_TIME + 1);
    localparam logic [PW-1:0] POS_FULL = PW'(TRAVEL);
    localparam logic [PW-1:0] POS_LAST = PW'(TRAVEL - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TIME);

    logic [NUM_SENSORS-1:0] w_filt;
    logic                   w_presence;
    logic                   w_lock;

    door_state_t   r_state, w_state_nx;
    logic [PW-1:0] r_pos, w_pos_nx;
    logic [HW-1:0] r_hold, w_hold_nx;

    for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_sensor
        door_sensor_filter #(
            .DEBOUNCE(DEBOUNCE)
        ) u_filter (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_raw (i_sensor[g]),
            .o_filt(w_filt[g])
        );
    end

    assign w_presence = |w_filt;

`ifdef DOOR_LOCK_EN
    logic [SYNC_STAGES-1:0] r_lock_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lock_sync <= '0;
        end else begin
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], i_lock};
        end
    end

    assign w_lock = r_lock_sync[SYNC_STAGES-1];
`else
    assign w_lock = 1'b0;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_pos_nx   = r_pos;
        w_hold_nx  = r_hold;
        case (r_state)
            CLOSED: begin
                w_pos_nx = '0;
                if (w_presence && !w_lock) begin
                    w_state_nx = OPENING;
                end
            end
            OPENING: begin
                // A reversal at full travel lands here with pos already at TRAVEL; clamp it.
                if (r_pos >= POS_LAST) begin
                    w_pos_nx   = POS_FULL;
                    w_hold_nx  = HOLD_MAX;
                    w_state_nx = OPEN_HOLD;
                end else begin
                    w_pos_nx = r_pos + PW'(1);
                end
            end
            OPEN_HOLD: begin
                if (w_presence) begin
                    w_hold_nx = HOLD_MAX;
                end else if (r_hold == '0) begin
                    w_state_nx = CLOSING;
                end else begin
                    w_hold_nx = r_hold - HW'(1);
                end
            end
            CLOSING: begin
                // Presence outranks reaching the closed end; pos is kept so reopening resumes here.
                if (w_presence) begin
                    w_state_nx = OPENING;
                end else if (r_pos <= PW'(1)) begin
                    w_pos_nx   = '0;
                    w_state_nx = CLOSED;
                end else begin
                    w_pos_nx = r_pos - PW'(1);
                end
            end
            default: begin
                w_state_nx = CLOSED;
                w_pos_nx   = '0;
                w_hold_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= CLOSED;
            r_pos   <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_pos   <= w_pos_nx;
            r_hold  <= w_hold_nx;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_motor_open        <= 1'b0;
            o_motor_close       <= 1'b0;
            o_door_output_state <= 1'b0;
            o_door_full_open    <= 1'b0;
        end else begin
            o_motor_open        <= is_moving(r_state) && (r_state == OPENING);
            o_motor_close       <= is_moving(r_state) && (r_state == CLOSING);
            o_door_output_state <= (r_state != CLOSED);
            o_door_full_open    <= (r_state == OPEN_HOLD);
        end
    end

endmodule

// File: tb/tb_multi_sensor_door_ctrl.sv
// Directed bench for multi_sensor_door_ctrl at default parameters; lock scenarios
// are included when DOOR_LOCK_EN is defined.
module tb_multi_sensor_door_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [1:0] i_sensor;
`ifdef DOOR_LOCK_EN
    logic       i_lock;
`endif
    logic       o_motor_open;
    logic       o_motor_close;
    logic       o_door_output_state;
    logic       o_door_full_open;

    int n_pass  = 0;
    int n_total = 0;

    always #5 i_clk = ~i_clk;

    multi_sensor_door_ctrl #(
        .NUM_SENSORS(2),
        .TRAVEL     (8),
        .HOLD_TIME  (16),
        .DEBOUNCE   (2)
    ) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_sensor           (i_sensor),
`ifdef DOOR_LOCK_EN
        .i_lock             (i_lock),
`endif
        .o_motor_open       (o_motor_open),
        .o_motor_close      (o_motor_close),
        .o_door_output_state(o_door_output_state),
        .o_door_full_open   (o_door_full_open)
    );

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // Edge index e counts rising edges after the one that first samples the sensor high.
    task automatic chk4(input string tag, input int e,
                        input logic mo, input logic fo, input logic mc, input logic ds);
        check($sformatf("%s@%0d motor_open", tag, e), o_motor_open, mo);
        check($sformatf("%s@%0d door_full_open", tag, e), o_door_full_open, fo);
        check($sformatf("%s@%0d motor_close", tag, e), o_motor_close, mc);
        check($sformatf("%s@%0d door_output_state", tag, e), o_door_output_state, ds);
    endtask

    initial begin
        i_rst    = 1'b1;
        i_sensor = 2'b00;
`ifdef DOOR_LOCK_EN
        i_lock   = 1'b0;
`endif

        for (int i = 0; i < 6; i++) begin
            i_sensor = i_sensor + 2'd1;
            step();
            chk4("reset_hold", i, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        i_sensor = 2'b00;
        i_rst    = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            step();
            chk4("reset_release", e, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        i_sensor = 2'b01;
        step();
        i_sensor = 2'b00;
        for (int e = 1; e <= 10; e++) begin
            step();
            chk4("glitch", e, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        i_sensor = 2'b10;
        step();
        for (int e = 1; e <= 45; e++) begin
            step();
            chk4("full", e, (e >= 5 && e <= 12), (e >= 13 && e <= 30),
                 (e >= 31 && e <= 38), (e >= 5 && e <= 38));
            if (e == 9) i_sensor = 2'b00;
        end

        // Reopen on sensor[0] while closing at pos 3 (CLOSING entered at edge 29).
        i_sensor = 2'b10;
        step();
        for (int e = 1; e <= 42; e++) begin
            step();
            chk4("reversal", e, (e >= 5 && e <= 12) || (e >= 36 && e <= 40),
                 (e >= 13 && e <= 29) || (e >= 41), (e >= 30 && e <= 35), (e >= 5));
            if (e == 2) i_sensor = 2'b00;
            if (e == 30) begin
                i_sensor = 2'b01;
`ifdef DOOR_LOCK_EN
                i_lock = 1'b1;
`endif
            end
        end

        i_sensor = 2'b00;
        #1 i_rst = 1'b1;
        #1 chk4("rst_async_hold", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 i_rst = 1'b0;
`ifdef DOOR_LOCK_EN
        i_lock = 1'b0;
`endif
        for (int e = 1; e <= 4; e++) begin
            step();
            chk4("idle_after_rst", e, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        i_sensor = 2'b01;
        step();
        for (int e = 1; e <= 8; e++) begin
            step();
            chk4("opening", e, (e >= 5), 1'b0, 1'b0, (e >= 5));
            if (e == 2) i_sensor = 2'b00;
        end
        #1 i_rst = 1'b1;
        #1 chk4("rst_async_open", 8, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 i_rst = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            step();
            chk4("idle_after_open_rst", e, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        i_sensor = 2'b10;
        step();
        for (int e = 1; e <= 14; e++) begin
            step();
            chk4("restart", e, (e >= 5 && e <= 12), (e >= 13), 1'b0, (e >= 5));
            if (e == 2) i_sensor = 2'b00;
        end

`ifdef DOOR_LOCK_EN
        #1 i_rst = 1'b1;
        #1 i_rst = 1'b0;
        i_lock = 1'b1;
        step();
        step();
        step();
        i_sensor = 2'b11;
        step();
        for (int e = 1; e <= 15; e++) begin
            step();
            chk4("locked_closed", e, 1'b0, 1'b0, 1'b0, 1'b0);
            if (e == 9) i_sensor = 2'b00;
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
